// File: rtl/count_sequencer_pkg.sv
// Shared types and constants for the count sequencer.
// State encoding, default terminal count and phase thresholds.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int DEFAULT_LIMIT = 6;
  localparam int PHASE_MAX     = 6;

  localparam int PH_T1 = 1;
  localparam int PH_T2 = 2;
  localparam int PH_T3 = 3;
  localparam int PH_T4 = 4;
  localparam int PH_T5 = 5;

endpackage

// File: rtl/count_sequencer_phase_decode.sv
// Combinational stage-code decode of the step count.
// Counts at or above the last threshold saturate to PHASE_MAX.
module phase_decode
  import count_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] count_i,
  output logic [2:0]       phase_o
);

  always_comb begin
    phase_o = 3'(PHASE_MAX);
    unique case (1'b1)
      (count_i >= CNT_W'(PH_T5)): phase_o = 3'(PHASE_MAX);
      (count_i == CNT_W'(PH_T4)): phase_o = 3'd5;
      (count_i == CNT_W'(PH_T3)): phase_o = 3'd4;
      (count_i == CNT_W'(PH_T2)): phase_o = 3'd3;
      (count_i == CNT_W'(PH_T1)): phase_o = 3'd2;
      (count_i == '0):            phase_o = 3'd1;
      default:                    phase_o = 3'(PHASE_MAX);
    endcase
  end

endmodule

// File: rtl/count_sequencer.sv
// Start/pause/abort step sequencer counting up to a latched limit.
// Emits a one-cycle done pulse on normal completion.
module count_sequencer #(
  parameter int CNT_W         = 16,
  parameter int DEFAULT_LIMIT = count_sequencer_pkg::DEFAULT_LIMIT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [CNT_W-1:0] limit_i,
  input  logic             pause_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] count_o,
  output logic [2:0]       phase_o
);

  import count_sequencer_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lim_q, lim_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lim_q   <= CNT_W'(DEFAULT_LIMIT);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    if (abort_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            lim_d   = (limit_i == '0) ? CNT_W'(DEFAULT_LIMIT)
                                      : limit_i;
            cnt_d   = '0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (pause_i) begin
            state_d = S_PAUSE;
          end else if (cnt_q == lim_q) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_PAUSE: begin
          // resume costs one cycle without an increment
          if (!pause_i) state_d = S_RUN;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done_o  = (state_q == S_DONE);
  assign count_o = cnt_q;

  phase_decode #(
    .CNT_W (CNT_W)
  ) u_phase (
    .count_i (cnt_q),
    .phase_o (phase_o)
  );

endmodule

// File: tb/tb_count_sequencer.sv
// Directed-vector bench for count_sequencer.
// Compares {busy, done, phase, count} against hand-derived values.
module tb_count_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, pause, abort;
  logic [15:0] limit;
  logic [3:0]  limit4;
  logic        busy, done;
  logic [15:0] count;
  logic [2:0]  phase;
  logic        busy4, done4;
  logic [3:0]  count4;
  logic [2:0]  phase4;

  int checks = 0;
  int errors = 0;

  logic [20:0] obs, exp_v;
  logic [8:0]  obs4, exp4;

  always #5 clk = ~clk;

  count_sequencer dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .limit_i (limit),
    .pause_i (pause),
    .abort_i (abort),
    .busy_o  (busy),
    .done_o  (done),
    .count_o (count),
    .phase_o (phase)
  );

  count_sequencer #(.CNT_W(4)) dut4 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .start_i (start),
    .limit_i (limit4),
    .pause_i (pause),
    .abort_i (abort),
    .busy_o  (busy4),
    .done_o  (done4),
    .count_o (count4),
    .phase_o (phase4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] ph(input int c);
    return (c >= 5) ? 3'd6 : 3'(c + 1);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 0; pause = 0; abort = 0;
    limit = '0; limit4 = '0;
    #3;
    obs = {busy, done, phase, count};
    exp_v = {1'b0, 1'b0, 3'd1, 16'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset: got %h want %h", obs, exp_v);
    end
    tick();
    rst_n = 1'b1;
    tick();
    obs = {busy, done, phase, count};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset_idle: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_default_limit();
    limit = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick();
      obs = {busy, done, phase, count};
      exp_v = {1'b1, 1'b0, ph(k), 16'(k)};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL default_run k=%0d: got %h want %h",
                 k, obs, exp_v);
      end
    end
    tick();
    obs = {busy, done, phase, count};
    exp_v = {1'b0, 1'b1, 3'd6, 16'd6};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL default_done: got %h want %h", obs, exp_v);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      obs = {busy, done, phase, count};
      exp_v = {1'b0, 1'b0, 3'd6, 16'd6};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL default_hold k=%0d: got %h want %h",
                 k, obs, exp_v);
      end
    end
  endtask

  task automatic test_pause();
    logic [20:0] seq [0:10];
    seq[0]  = {1'b1, 1'b0, 3'd1, 16'd0};
    seq[1]  = {1'b1, 1'b0, 3'd2, 16'd1};
    seq[2]  = {1'b1, 1'b0, 3'd3, 16'd2};
    seq[3]  = {1'b1, 1'b0, 3'd3, 16'd2};
    seq[4]  = {1'b1, 1'b0, 3'd3, 16'd2};
    seq[5]  = {1'b1, 1'b0, 3'd3, 16'd2};
    seq[6]  = {1'b1, 1'b0, 3'd3, 16'd2};
    seq[7]  = {1'b1, 1'b0, 3'd3, 16'd2};
    seq[8]  = {1'b1, 1'b0, 3'd4, 16'd3};
    seq[9]  = {1'b0, 1'b1, 3'd4, 16'd3};
    seq[10] = {1'b0, 1'b0, 3'd4, 16'd3};
    limit = 16'd3; start = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      tick();
      start = 1'b0;
      pause = (k >= 2 && k <= 5);
      obs = {busy, done, phase, count};
      checks++;
      if (obs !== seq[k]) begin
        errors++;
        $display("FAIL pause k=%0d: got %h want %h",
                 k, obs, seq[k]);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_abort();
    limit = 16'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    obs = {busy, done, phase, count};
    exp_v = {1'b1, 1'b0, 3'd5, 16'd4};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_pre: got %h want %h", obs, exp_v);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_v = {1'b0, 1'b0, 3'd1, 16'd0};
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      obs = {busy, done, phase, count};
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL abort_idle k=%0d: got %h want %h",
                 k, obs, exp_v);
      end
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    obs = {busy, done, phase, count};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL abort_vs_start: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_ignore_start();
    logic [20:0] seq [0:4];
    seq[0] = {1'b1, 1'b0, 3'd1, 16'd0};
    seq[1] = {1'b1, 1'b0, 3'd2, 16'd1};
    seq[2] = {1'b1, 1'b0, 3'd3, 16'd2};
    seq[3] = {1'b0, 1'b1, 3'd3, 16'd2};
    seq[4] = {1'b0, 1'b0, 3'd3, 16'd2};
    limit = 16'd2; start = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      tick();
      limit = 16'd5;
      obs = {busy, done, phase, count};
      checks++;
      if (obs !== seq[k]) begin
        errors++;
        $display("FAIL ignore_start k=%0d: got %h want %h",
                 k, obs, seq[k]);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    limit = 16'd6; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    obs = {busy, done, phase, count};
    exp_v = {1'b1, 1'b0, 3'd6, 16'd5};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rst_mid_pre: got %h want %h", obs, exp_v);
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {busy, done, phase, count};
    exp_v = {1'b0, 1'b0, 3'd1, 16'd0};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rst_mid_now: got %h want %h", obs, exp_v);
    end
    start = 1'b1; limit = 16'd1;
    tick();
    obs = {busy, done, phase, count};
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL rst_mid_held: got %h want %h", obs, exp_v);
    end
    rst_n = 1'b1;
    begin
      logic [20:0] seq [0:3];
      seq[0] = {1'b1, 1'b0, 3'd1, 16'd0};
      seq[1] = {1'b1, 1'b0, 3'd2, 16'd1};
      seq[2] = {1'b0, 1'b1, 3'd2, 16'd1};
      seq[3] = {1'b0, 1'b0, 3'd2, 16'd1};
      for (int k = 0; k <= 3; k++) begin
        tick();
        start = 1'b0;
        obs = {busy, done, phase, count};
        checks++;
        if (obs !== seq[k]) begin
          errors++;
          $display("FAIL rst_after k=%0d: got %h want %h",
                   k, obs, seq[k]);
        end
      end
    end
  endtask

  task automatic test_max_limit();
    int pulses;
    pulses = 0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    limit4 = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) tick();
      if (done4) pulses++;
      obs4 = {busy4, done4, phase4, count4};
      exp4 = {1'b1, 1'b0, ph(k), 4'(k)};
      checks++;
      if (obs4 !== exp4) begin
        errors++;
        $display("FAIL max_run k=%0d: got %h want %h",
                 k, obs4, exp4);
      end
    end
    tick();
    if (done4) pulses++;
    obs4 = {busy4, done4, phase4, count4};
    exp4 = {1'b0, 1'b1, 3'd6, 4'd15};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL max_done: got %h want %h", obs4, exp4);
    end
    repeat (3) begin
      tick();
      if (done4) pulses++;
    end
    obs4 = {busy4, done4, phase4, count4};
    exp4 = {1'b0, 1'b0, 3'd6, 4'd15};
    checks++;
    if (obs4 !== exp4) begin
      errors++;
      $display("FAIL max_hold: got %h want %h", obs4, exp4);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL max_pulses: got %0d want 1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_default_limit();
    test_pause();
    test_abort();
    test_ignore_start();
    test_reset_mid_run();
    test_max_limit();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
